// File: rtl/gba_io_pkg.sv
// Shared definitions for the GBA cart / USB memory mux.
//   WIDTH_*      : access-width encodings on cart_data_width / mem_data_width
//   mux_state_e  : arbiter FSM states
//   cart_req_t   : contents of the 1-deep pending cart request slot
package gba_io_pkg;

  localparam logic [1:0] WIDTH_8  = 2'b01;
  localparam logic [1:0] WIDTH_16 = 2'b10;
  localparam logic [1:0] WIDTH_32 = 2'b11;

  // Address width held in the pending slot; the top's ADDR_W defaults to it.
  localparam int GBA_ADDR_W = 26;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_RD
  } mux_state_e;

  typedef struct packed {
    logic                  rd;
    logic [1:0]            width;
    logic [GBA_ADDR_W-1:0] addr;
    logic [15:0]           wdata;
  } cart_req_t;

endpackage

// File: rtl/gba_cart_req_slot.sv
// 1-deep capture register for cart request pulses.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   cart_rd/cart_wr       : one-cycle request pulses (rd wins if both)
//   cart_data_width/addr/wr_data : request attributes captured with the pulse
//   free                  : owner finished (or dropped) the held request
//   slot_valid/slot_req   : held request
//   overrun               : sticky, a pulse arrived while the slot was full
module gba_cart_req_slot
  import gba_io_pkg::*;
#(
  parameter int ADDR_W = GBA_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cart_rd,
  input  logic              cart_wr,
  input  logic [1:0]        cart_data_width,
  input  logic [ADDR_W-1:0] cart_addr,
  input  logic [15:0]       cart_wr_data,
  input  logic              free,
  output logic              slot_valid,
  output cart_req_t         slot_req,
  output logic              overrun
);

  logic      valid_q, valid_d;
  cart_req_t req_q, req_d;
  logic      overrun_q, overrun_d;

  always_comb begin
    // A free in the same cycle as a new pulse makes room for it.
    valid_d   = valid_q & ~free;
    req_d     = req_q;
    overrun_d = overrun_q;
    if (cart_rd || cart_wr) begin
      if (valid_d) begin
        overrun_d = 1'b1;
      end else begin
        valid_d     = 1'b1;
        req_d.rd    = cart_rd;
        req_d.width = cart_data_width;
        req_d.addr  = GBA_ADDR_W'(cart_addr);
        req_d.wdata = cart_wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      req_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      req_q     <= req_d;
      overrun_q <= overrun_d;
    end
  end

  assign slot_valid = valid_q;
  assign slot_req   = req_q;
  assign overrun    = overrun_q;

endmodule

// File: rtl/gba_cart_usb_mem_mux.sv
// Arbiter between the GBA cart front end and the USB bridge onto one memory
// controller. Cart has strict priority; one cart request can wait in a slot
// while a USB operation completes.
// Ports:
//   cart_*     : cart request pulses in, read data + mux_rd_valid out
//   usb_*      : level requests in, ready/valid pulses + read data out
//   from_*, cart_usb_addr / buf_mem_addr : source + address to/from buffer
//   mem_*      : memory request/handshake, mem_addr = buf_mem_addr
//   cart_overrun, mem_timeout : sticky error flags
module gba_cart_usb_mem_mux
  import gba_io_pkg::*;
#(
  parameter int ADDR_W      = GBA_ADDR_W,
  parameter int MEM_TIMEOUT = 1024,
  parameter int TO_W        = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cart_rd,
  input  logic              cart_wr,
  input  logic [1:0]        cart_data_width,
  input  logic [ADDR_W-1:0] cart_addr,
  input  logic [15:0]       cart_wr_data,
  output logic [15:0]       cart_rd_data,
  output logic              mux_rd_valid,
  input  logic              usb_rd,
  input  logic              usb_wr,
  input  logic [ADDR_W-1:0] usb_addr,
  input  logic [31:0]       usb_wr_data,
  output logic              usb_rd_ready,
  output logic              usb_wr_ready,
  output logic [31:0]       usb_rd_data,
  output logic              usb_rd_valid,
  output logic              from_cart,
  output logic              from_usb,
  output logic [ADDR_W-1:0] cart_usb_addr,
  input  logic [ADDR_W-1:0] buf_mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic              mem_rd_ready,
  input  logic              mem_wr_ready,
  input  logic              mem_rd_valid,
  output logic [1:0]        mem_data_width,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rd_data,
  output logic [31:0]       mem_wr_data,
  output logic              cart_overrun,
  output logic              mem_timeout
);

  mux_state_e        state_q, state_d;
  logic              src_cart_q, src_cart_d;
  logic              is_rd_q, is_rd_d;
  logic [1:0]        width_q, width_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [15:0]       cart_rd_data_q, cart_rd_data_d;
  logic [31:0]       usb_rd_data_q, usb_rd_data_d;
  logic              mux_rd_valid_q, mux_rd_valid_d;
  logic              usb_rd_valid_q, usb_rd_valid_d;
  logic              timeout_q, timeout_d;

  logic      slot_valid, slot_free, mem_accept, timed_out, busy;
  cart_req_t slot_req;

  gba_cart_req_slot #(.ADDR_W(ADDR_W)) u_slot (
    .clk             (clk),
    .rst             (rst),
    .cart_rd         (cart_rd),
    .cart_wr         (cart_wr),
    .cart_data_width (cart_data_width),
    .cart_addr       (cart_addr),
    .cart_wr_data    (cart_wr_data),
    .free            (slot_free),
    .slot_valid      (slot_valid),
    .slot_req        (slot_req),
    .overrun         (cart_overrun)
  );

  assign mem_accept = is_rd_q ? mem_rd_ready : mem_wr_ready;
  assign timed_out  = (to_cnt_q == TO_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d        = state_q;
    src_cart_d     = src_cart_q;
    is_rd_d        = is_rd_q;
    width_d        = width_q;
    wdata_d        = wdata_q;
    addr_d         = addr_q;
    to_cnt_d       = to_cnt_q + 1'b1;
    cart_rd_data_d = cart_rd_data_q;
    usb_rd_data_d  = usb_rd_data_q;
    mux_rd_valid_d = 1'b0;
    usb_rd_valid_d = 1'b0;
    timeout_d      = timeout_q;
    slot_free      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Counter parked at zero so it starts fresh on entry to REQ.
        to_cnt_d = '0;
        if (slot_valid) begin
          src_cart_d = 1'b1;
          is_rd_d    = slot_req.rd;
          width_d    = slot_req.width;
          wdata_d    = {16'h0, slot_req.wdata};
          addr_d     = ADDR_W'(slot_req.addr);
          state_d    = ST_REQ;
        end else if (!(cart_rd || cart_wr) && (usb_rd || usb_wr)) begin
          // A cart pulse landing this cycle fills the slot next cycle;
          // hold USB off so it cannot jump ahead of it.
          src_cart_d = 1'b0;
          is_rd_d    = usb_rd;
          width_d    = WIDTH_32;
          wdata_d    = usb_wr_data;
          addr_d     = usb_addr;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_accept) begin
          to_cnt_d = '0;
          if (is_rd_q) begin
            state_d = ST_WAIT_RD;
          end else begin
            state_d   = ST_IDLE;
            slot_free = src_cart_q;
          end
        end else if (timed_out) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
          slot_free = src_cart_q;
        end
      end
      ST_WAIT_RD: begin
        if (mem_rd_valid) begin
          state_d   = ST_IDLE;
          slot_free = src_cart_q;
          if (src_cart_q) begin
            mux_rd_valid_d = 1'b1;
            cart_rd_data_d = (width_q == WIDTH_8) ? {8'h0, mem_rd_data[7:0]}
                                                  : mem_rd_data[15:0];
          end else begin
            usb_rd_valid_d = 1'b1;
            usb_rd_data_d  = mem_rd_data;
          end
        end else if (timed_out) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
          slot_free = src_cart_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      src_cart_q     <= 1'b0;
      is_rd_q        <= 1'b0;
      width_q        <= '0;
      wdata_q        <= '0;
      addr_q         <= '0;
      to_cnt_q       <= '0;
      cart_rd_data_q <= '0;
      usb_rd_data_q  <= '0;
      mux_rd_valid_q <= 1'b0;
      usb_rd_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      src_cart_q     <= src_cart_d;
      is_rd_q        <= is_rd_d;
      width_q        <= width_d;
      wdata_q        <= wdata_d;
      addr_q         <= addr_d;
      to_cnt_q       <= to_cnt_d;
      cart_rd_data_q <= cart_rd_data_d;
      usb_rd_data_q  <= usb_rd_data_d;
      mux_rd_valid_q <= mux_rd_valid_d;
      usb_rd_valid_q <= usb_rd_valid_d;
      timeout_q      <= timeout_d;
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign from_cart      = busy & src_cart_q;
  assign from_usb       = busy & ~src_cart_q;
  assign mem_rd         = (state_q == ST_REQ) & is_rd_q;
  assign mem_wr         = (state_q == ST_REQ) & ~is_rd_q;
  assign usb_rd_ready   = mem_rd & ~src_cart_q & mem_rd_ready;
  assign usb_wr_ready   = mem_wr & ~src_cart_q & mem_wr_ready;
  assign mem_data_width = busy ? width_q : 2'b00;
  assign mem_wr_data    = mem_wr ? wdata_q : 32'h0;
  assign mem_addr       = buf_mem_addr;
  assign cart_usb_addr  = addr_q;
  assign cart_rd_data   = cart_rd_data_q;
  assign usb_rd_data    = usb_rd_data_q;
  assign mux_rd_valid   = mux_rd_valid_q;
  assign usb_rd_valid   = usb_rd_valid_q;
  assign mem_timeout    = timeout_q;

endmodule
